// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, frame defaults and header helper for the UART frame scheduler
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        HDR,
        PAYLOAD,
        CSUM
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
    localparam int         MAX_LEN_DEF   = 32;

    // Header byte carries the owning channel in its two low bits
    function automatic logic [7:0] hdr_byte(input logic [1:0] id);
        return {6'b0, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, one-hot grant, pointer advances past the winner on enable
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int W = N > 1 ? $clog2(N) : 1;

    logic [W-1:0] ptr_q, ptr_d;
    logic [W:0]   idx;
    logic         found;

    // Scan from the pointer with wrap-around; the first requester wins and the pointer moves just past it
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (W+1)'(i);
            if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
            if (!found && req[idx[W-1:0]]) begin
                found              = 1'b1;
                gnt[idx[W-1:0]]    = 1'b1;
                if (en) ptr_d = (idx == (W+1)'(N-1)) ? '0 : W'(idx + 1'b1);
            end
        end
    end

    // Pointer register; channel 0 is first in line after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: frames per-channel byte streams (sync, header, payload, xor checksum) onto one UART
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int         NUM_CH    = 3,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_LEN   = MAX_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [8*NUM_CH-1:0] src_data,
    input  logic [NUM_CH-1:0]   src_valid,
    input  logic [NUM_CH-1:0]   src_last,
    output logic [NUM_CH-1:0]   src_ready,
    output logic [7:0]          tx_data,
    output logic                tx_data_valid,
    input  logic                tx_data_ready,
    output logic [1:0]          grant_id,
    output logic                busy
);

    state_e      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        csum_sent_q, csum_sent_d;
    logic        cool_q, cool_d;

    logic [NUM_CH-1:0] arb_req, arb_gnt;
    logic              arb_en;
    logic [1:0]        gnt_idx;
    logic [7:0]        sel_data;
    logic              sel_valid, sel_last;
    logic              xfer, ready_g, accept;

    // The cycle right after a checksum transfer is kept out of arbitration
    assign arb_req   = cool_q ? '0 : src_valid;
    assign arb_en    = (state_q == IDLE) && |arb_req;
    assign sel_data  = src_data[{grant_q, 3'b000} +: 8];
    assign sel_valid = src_valid[grant_q];
    assign sel_last  = src_last[grant_q];
    assign xfer      = tx_valid_q && tx_data_ready;
    assign ready_g   = (state_q == PAYLOAD) && (!tx_valid_q || tx_data_ready);
    assign accept    = ready_g && sel_valid;

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign grant_id      = grant_q;
    assign busy          = state_q != IDLE;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .en    (arb_en),
        .gnt   (arb_gnt)
    );

    // Convert the one-hot grant into the channel number carried in the header
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (arb_gnt[i]) gnt_idx = 2'(i);
    end

    // Only the owning channel sees ready, and only while the output slot is free or draining
    always_comb begin
        src_ready          = '0;
        src_ready[grant_q] = ready_g;
    end

    // Frame sequencer: next state, output byte, running checksum and payload count
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        grant_d     = grant_q;
        csum_d      = csum_q;
        cnt_d       = cnt_q;
        csum_sent_d = csum_sent_q;
        cool_d      = 1'b0;
        case (state_q)
            IDLE: if (arb_en) begin
                grant_d    = gnt_idx;
                tx_data_d  = SYNC_BYTE;
                tx_valid_d = 1'b1;
                state_d    = SYNC;
            end
            SYNC: if (xfer) begin
                tx_data_d = hdr_byte(grant_q);
                csum_d    = hdr_byte(grant_q);
                state_d   = HDR;
            end
            HDR: if (xfer) begin
                tx_valid_d = 1'b0;
                cnt_d      = '0;
                state_d    = PAYLOAD;
            end
            PAYLOAD: if (accept) begin
                tx_data_d  = sel_data;
                tx_valid_d = 1'b1;
                csum_d     = csum_q ^ sel_data;
                cnt_d      = cnt_q + 8'd1;
                if (sel_last || (cnt_q + 8'd1 == 8'(MAX_LEN))) begin
                    csum_sent_d = 1'b0;
                    state_d     = CSUM;
                end
            end else if (xfer) begin
                tx_valid_d = 1'b0;
            end
            CSUM: if (xfer) begin
                if (csum_sent_q) begin
                    tx_valid_d = 1'b0;
                    cool_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tx_data_d   = csum_q;
                    csum_sent_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            grant_q     <= '0;
            csum_q      <= '0;
            cnt_q       <= '0;
            csum_sent_q <= 1'b0;
            cool_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            grant_q     <= grant_d;
            csum_q      <= csum_d;
            cnt_q       <= cnt_d;
            csum_sent_q <= csum_sent_d;
            cool_q      <= cool_d;
        end
    end

endmodule
